mano_fetch_unit: RTL and testbench

Instruction-fetch initiator for the 16×8 basic-computer memory. It drives the memory's read strobe and address (AR), latches the instruction word, advances the program counter and resolves one level of indirect addressing. It presents a decoded instruction and effective address to the execute stage over a valid/ready handshake. It sits between the program counter/control sequencer and the memory's read port.

---
 rtl/mano_pkg.sv | 12 +
 rtl/mano_fetch_unit.sv | 71 +++++++
 tb/tb_mano_fetch_unit.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mano_pkg.sv
// mano_pkg: shared types and constants for the basic-computer fetch unit.
package mano_pkg;
    localparam int DEF_ADDR_W = 4;
    localparam int DEF_DATA_W = 8;
    localparam int I_BIT = 7;
    localparam int OP_HI = 6;
    localparam int OP_LO = 4;
    localparam int AD_HI = 3;
    localparam int AD_LO = 0;
    localparam logic [2:0] OP_REG = 3'b111;
    typedef enum logic [1:0] {IDLE, FETCH, INDIRECT, VALID} state_t;
endpackage

// File: rtl/mano_fetch_unit.sv
// mano_fetch_unit: fetches instruction words, resolves one indirect level and
// hands {ir, ea} to the execute stage over valid/ready.
module mano_fetch_unit
    import mano_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] pc_load_val,
    input  logic              ins_ready,
    output logic              ins_valid,
    output logic [DATA_W-1:0] ir,
    output logic [2:0]        opcode,
    output logic              ind,
    output logic [ADDR_W-1:0] ea,
    output logic [ADDR_W-1:0] pc,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_ar,
    input  logic [DATA_W-1:0] mem_outdata
);
    state_t state, nxt;
    logic   fetch_ind;

    // register-reference/IO words never take the indirect cycle
    assign fetch_ind = mem_outdata[I_BIT] && (mem_outdata[OP_HI:OP_LO] != OP_REG);

    always_comb begin
        nxt = state;
        if (pc_load) nxt = start ? FETCH : IDLE;
        else begin
            case (state)
                IDLE:     nxt = start ? FETCH : IDLE;
                FETCH:    nxt = fetch_ind ? INDIRECT : VALID;
                INDIRECT: nxt = VALID;
                VALID:    nxt = ins_ready ? (start ? FETCH : IDLE) : VALID;
                default:  nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            pc    <= RESET_PC;
            ir    <= '0;
            ea    <= '0;
        end else begin
            state <= nxt;
            // a redirect aborts the in-flight read, so ir/ea keep their old values
            if (pc_load) pc <= pc_load_val;
            else if (state == FETCH) begin
                pc <= pc + 1'b1;
                ir <= mem_outdata;
                if (!fetch_ind) ea <= mem_outdata[AD_HI:AD_LO];
            end else if (state == INDIRECT) ea <= mem_outdata[AD_HI:AD_LO];
        end
    end

    assign ins_valid = (state == VALID);
    assign mem_read  = (state == FETCH) || (state == INDIRECT);
    assign mem_write = 1'b0;
    assign mem_ar    = (state == FETCH) ? pc : (state == INDIRECT) ? ir[AD_HI:AD_LO] : '0;
    assign opcode    = ir[OP_HI:OP_LO];
    assign ind       = ir[I_BIT];
endmodule

// File: tb/tb_mano_fetch_unit.sv
// tb_mano_fetch_unit: directed vector table, corner sequences and a randomized
// run checked against a transaction-level model of the instruction stream.
module tb_mano_fetch_unit;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       pc_load = 1'b0;
    logic [3:0] pc_load_val = '0;
    logic       ins_ready = 1'b0;
    logic       ins_valid;
    logic [7:0] ir;
    logic [2:0] opcode;
    logic       ind;
    logic [3:0] ea;
    logic [3:0] pc;
    logic       mem_read;
    logic       mem_write;
    logic [3:0] mem_ar;
    logic [7:0] mem_outdata;
    logic [7:0] mem [16];

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    assign mem_outdata = mem[mem_ar];

    mano_fetch_unit dut (
        .clk(clk), .rst_n(rst_n), .start(start), .pc_load(pc_load),
        .pc_load_val(pc_load_val), .ins_ready(ins_ready), .ins_valid(ins_valid),
        .ir(ir), .opcode(opcode), .ind(ind), .ea(ea), .pc(pc),
        .mem_read(mem_read), .mem_write(mem_write), .mem_ar(mem_ar),
        .mem_outdata(mem_outdata)
    );

    typedef struct {
        logic [3:0] pcv;
        logic [7:0] ir;
        logic [3:0] ea;
        logic [3:0] ind_ar;
        int         lat;
    } vec_t;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_valid(input int maxc, output int n);
        n = 0;
        while (!ins_valid && n < maxc) begin
            step();
            n++;
        end
        if (!ins_valid) chk("valid_timeout", 16'(ins_valid), 16'd1);
    endtask

    // expected effective address straight from the instruction-format rules
    function automatic logic [3:0] ref_ea(input logic [3:0] a);
        logic [7:0] w;
        w = mem[a];
        return (w[7] && w[6:4] != 3'b111) ? mem[w[3:0]][3:0] : w[3:0];
    endfunction

    vec_t vecs [8];

    initial begin
        int n, lat, xfers;
        logic [3:0] exp_pc, pv;
        logic [7:0] hold_ir;
        logic [3:0] hold_ea;
        logic pl, exp_drop;

        vecs[0] = '{4'd0,  8'h0A, 4'hA, 4'h0, 1};
        vecs[1] = '{4'd1,  8'h1B, 4'hB, 4'h0, 1};
        vecs[2] = '{4'd7,  8'h8D, 4'h9, 4'hD, 2};
        vecs[3] = '{4'd10, 8'hC4, 4'h8, 4'h4, 2};
        vecs[4] = '{4'd11, 8'hFF, 4'hF, 4'h0, 1};
        vecs[5] = '{4'd4,  8'h78, 4'h8, 4'h0, 1};
        vecs[6] = '{4'd13, 8'h19, 4'h9, 4'h0, 1};
        vecs[7] = '{4'd15, 8'h0B, 4'hB, 4'h0, 1};

        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        mem[0] = 8'h0A; mem[1] = 8'h1B; mem[4] = 8'h78; mem[7] = 8'h8D;
        mem[10] = 8'hC4; mem[11] = 8'hFF; mem[13] = 8'h19; mem[15] = 8'h0B;

        #12;
        chk("rst_valid", 16'(ins_valid), 16'd0);
        chk("rst_read", 16'(mem_read), 16'd0);
        chk("rst_write", 16'(mem_write), 16'd0);
        chk("rst_ar", 16'(mem_ar), 16'd0);
        chk("rst_pc", 16'(pc), 16'd0);
        chk("rst_ir", 16'(ir), 16'd0);
        chk("rst_ea", 16'(ea), 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("idle_read", 16'(mem_read), 16'd0);

        // first two instructions from reset with ready held high
        start = 1'b1;
        ins_ready = 1'b1;
        step();
        chk("f0_read", 16'(mem_read), 16'd1);
        chk("f0_ar", 16'(mem_ar), 16'd0);
        step();
        chk("f0_valid", 16'(ins_valid), 16'd1);
        chk("f0_ir", 16'(ir), 16'h0A);
        chk("f0_opcode", 16'(opcode), 16'd0);
        chk("f0_ind", 16'(ind), 16'd0);
        chk("f0_ea", 16'(ea), 16'hA);
        chk("f0_pc", 16'(pc), 16'd1);
        chk("f0_vread", 16'(mem_read), 16'd0);
        step();
        chk("f1_ar", 16'(mem_ar), 16'd1);
        chk("f1_nvalid", 16'(ins_valid), 16'd0);
        step();
        chk("f1_ir", 16'(ir), 16'h1B);
        chk("f1_ea", 16'(ea), 16'hB);
        ins_ready = 1'b0;

        // each vector redirects the stalled VALID instruction to a new PC
        for (int i = 0; i < 8; i++) begin
            pc_load = 1'b1;
            pc_load_val = vecs[i].pcv;
            step();
            pc_load = 1'b0;
            chk($sformatf("v%0d_fetch_ar", i), 16'(mem_ar), 16'(vecs[i].pcv));
            chk($sformatf("v%0d_fetch_rd", i), 16'(mem_read), 16'd1);
            chk($sformatf("v%0d_drop", i), 16'(ins_valid), 16'd0);
            step();
            lat = 1;
            if (!ins_valid) begin
                chk($sformatf("v%0d_ind_rd", i), 16'(mem_read), 16'd1);
                chk($sformatf("v%0d_ind_ar", i), 16'(mem_ar), 16'(vecs[i].ind_ar));
                wait_valid(6, n);
                lat = 1 + n;
            end
            chk($sformatf("v%0d_lat", i), 16'(lat), 16'(vecs[i].lat));
            chk($sformatf("v%0d_ir", i), 16'(ir), 16'(vecs[i].ir));
            chk($sformatf("v%0d_opcode", i), 16'(opcode), 16'(vecs[i].ir[6:4]));
            chk($sformatf("v%0d_ind", i), 16'(ind), 16'(vecs[i].ir[7]));
            chk($sformatf("v%0d_ea", i), 16'(ea), 16'(vecs[i].ea));
            chk($sformatf("v%0d_pc", i), 16'(pc), 16'(4'(vecs[i].pcv + 4'd1)));
        end

        // after 0B at address 15 the PC has wrapped, so the next word is M0
        ins_ready = 1'b1;
        step();
        ins_ready = 1'b0;
        chk("wrap_ar", 16'(mem_ar), 16'd0);
        wait_valid(6, n);
        chk("wrap_ir", 16'(ir), 16'h0A);

        hold_ir = ir;
        hold_ea = ea;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_valid", 16'(ins_valid), 16'd1);
            chk("stall_ir", 16'(ir), 16'(hold_ir));
            chk("stall_ea", 16'(ea), 16'(hold_ea));
            chk("stall_read", 16'(mem_read), 16'd0);
        end

        // redirect with ready in the same cycle: the held instruction is lost
        pc_load = 1'b1;
        pc_load_val = 4'd4;
        ins_ready = 1'b1;
        step();
        pc_load = 1'b0;
        chk("abort_valid", 16'(ins_valid), 16'd0);
        chk("abort_ar", 16'(mem_ar), 16'd4);
        wait_valid(6, n);
        chk("abort_ir", 16'(ir), 16'h78);
        ins_ready = 1'b0;

        // reset asserted while the indirect read of 8D is in flight
        pc_load = 1'b1;
        pc_load_val = 4'd7;
        step();
        pc_load = 1'b0;
        step();
        chk("ri_read", 16'(mem_read), 16'd1);
        chk("ri_ar", 16'(mem_ar), 16'hD);
        #1 rst_n = 1'b0;
        start = 1'b0;
        #1;
        chk("ri_rst_read", 16'(mem_read), 16'd0);
        chk("ri_rst_ar", 16'(mem_ar), 16'd0);
        chk("ri_rst_pc", 16'(pc), 16'd0);
        chk("ri_rst_ir", 16'(ir), 16'd0);
        chk("ri_rst_ea", 16'(ea), 16'd0);
        chk("ri_rst_valid", 16'(ins_valid), 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("ri_quiet_read", 16'(mem_read), 16'd0);
        end
        start = 1'b1;
        step();
        chk("ri_start_read", 16'(mem_read), 16'd1);
        chk("ri_start_ar", 16'(mem_ar), 16'd0);

        // randomized run: every transfer must match the next word in program order
        rst_n = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
        @(negedge clk);
        rst_n = 1'b1;
        exp_pc = 4'd0;
        exp_drop = 1'b0;
        xfers = 0;
        pv = '0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (exp_drop) begin
                chk("rand_drop_valid", 16'(ins_valid), 16'd0);
                chk("rand_load_pc", 16'(pc), 16'(pv));
            end
            ins_ready = 1'($urandom_range(0, 1));
            start = ($urandom_range(0, 7) != 0);
            pl = ($urandom_range(0, 15) == 0);
            pv = 4'($urandom);
            pc_load = pl;
            pc_load_val = pv;
            if (pl) exp_pc = pv;
            else if (ins_valid && ins_ready) begin
                xfers++;
                chk("rand_ir", 16'(ir), 16'(mem[exp_pc]));
                chk("rand_ea", 16'(ea), 16'(ref_ea(exp_pc)));
                chk("rand_pc", 16'(pc), 16'(4'(exp_pc + 4'd1)));
                exp_pc = exp_pc + 4'd1;
            end
            exp_drop = pl;
        end
        pc_load = 1'b0;
        chk("rand_xfers", 16'(xfers > 100), 16'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
